instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Upstream neighbour of the immediate/decode stage.
- Owns the fetch PC and issues word requests to instruction memory over a request/grant/response handshake.
- Buffers returned words with their PCs in a 2-entry FIFO and presents them to decode with a valid/ready handshake.
- Accepts branch/jump redirects computed from the decoded immediate (PC + imm) and flushes stale fetches.

Parameters:
RESET_PC, 32'h0040_0000, first fetch address after reset
DEPTH, 2, instruction buffer entries (fixed at 2; counter width 2 bits)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req_o  output  1  fetch request valid
imem_addr_o  output  32  fetch word address, bits [1:0] always 0
imem_gnt_i  input  1  memory accepted request this cycle
imem_rvalid_i  input  1  read data valid (earliest one cycle after gnt)
imem_rdata_i  input  32  fetched instruction word
redirect_i  input  1  branch/jump taken, restart fetch
redirect_pc_i  input  32  redirect target
inst_valid_o  output  1  buffer head valid
inst_ready_i  input  1  decode accepts head
Instruction_bus_o  output  32  head instruction word
pc_o  output  32  head instruction PC
op_o  output  7  Instruction_bus_o[6:0], feeds immediate unit op select

Behaviour:
- Reset (async, reset==0): state IDLE, fetch_pc=RESET_PC, buffer empty, imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, Instruction_bus_o=32'h0000_0013 (NOP), pc_o=0, op_o=7'h13.
- At most one outstanding request. imem_addr_o=fetch_pc in every state; imem_req_o=1 only in REQ.
- States:
  - IDLE: go to REQ when count<DEPTH, where count is evaluated after this cycle's pop.
  - REQ: hold request. On gnt: latch req_pc=fetch_pc, fetch_pc+=4 (wraps mod 2^32), go to WAIT.
  - WAIT: on rvalid, push {req_pc, rdata}. Next state is REQ if count after push and pop <DEPTH, else IDLE.
  - DROP: on rvalid, discard the data and go to REQ.
- imem_rvalid_i outside WAIT/DROP is ignored.
- Because a request is only issued when a slot is free, a push never finds the buffer full.
- Decode handshake:
  - pop when inst_valid_o && inst_ready_i.
  - Push and pop in the same cycle are both honoured.
  - Outputs show the head entry; when empty they show the NOP/0 values above.
  - Head must stay stable while valid and not popped.
- Redirect (highest priority, sampled at rising edge):
  - Buffer flushed; any same-cycle pop is absorbed, so count=0 next cycle.
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}.
  - REQ without gnt: stay in REQ with the new address. This is the only case imem_addr_o may change while imem_req_o=1.
  - REQ with gnt: go to DROP.
  - WAIT with rvalid: discard the data, go to REQ.
  - WAIT without rvalid: go to DROP.
  - DROP: stay in DROP.
  - IDLE: go to REQ.
- Redirect while in DROP keeps a single pending discard; it never drops twice.
- Reset asserted mid-operation returns immediately to the reset values. A memory response arriving after reset release while in IDLE is ignored.
- Throughput: one instruction per 2 cycles with zero-wait memory (REQ+gnt, WAIT+rvalid).

Test Plan:
- Reset: hold reset=0 with gnt=1 -> imem_req_o=0, inst_valid_o=0, op_o=7'h13. After release: imem_req_o=1, imem_addr_o=32'h0040_0000.
- Streaming: gnt=1 always, rvalid one cycle after gnt, rdata=addr-derived words, ready=1 -> decode sees PCs 0x400000, 0x400004, 0x400008 in order, with matching words and op_o.
- Backpressure: ready=0 -> after two pushes imem_req_o stays 0 and count=2. Raise ready for one cycle -> one pop, exactly one new request issued, order preserved.
- Redirect in WAIT: redirect_pc_i=32'h0040_0103 the cycle after gnt, rvalid next cycle -> that word never appears. The next request address is 32'h0040_0100, and the buffer is empty the cycle after redirect.
- Redirect in REQ without gnt: hold gnt=0, pulse redirect to 0x400200 -> imem_req_o stays 1 and imem_addr_o changes to 0x400200. Only that address's word is delivered.
- Async reset mid-WAIT: assert reset between clock edges -> outputs reach reset values without a clock edge. A late rvalid after release is ignored, and fetch restarts at 0x400000.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, redirect input and
// the decode-side valid/ready head of the instruction buffer.
interface instruction_fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] Instruction_bus_o;
    logic [31:0] pc_o;
    logic [6:0]  op_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  redirect_i, redirect_pc_i,
        output inst_valid_o, Instruction_bus_o, pc_o, op_o,
        input  inst_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output redirect_i, redirect_pc_i,
        input  inst_valid_o, Instruction_bus_o, pc_o, op_o,
        output inst_ready_i
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch unit: owns the fetch PC, keeps one request outstanding to instruction
// memory and buffers returned words with their PCs in a 2-entry FIFO for decode.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  bus
);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [1:0]  DEPTH_C = 2'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

    state_e            state_q, state_d;
    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic [1:0]        count_q, count_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0][31:0]  buf_pc_q, buf_pc_d;
    logic [1:0][31:0]  buf_ins_q, buf_ins_d;
    logic              pop, push, head_vld;
    logic [1:0]        cnt_pop;
    logic [31:0]       head_ins;

    assign head_vld = (count_q != 2'd0);
    assign pop      = head_vld && bus.inst_ready_i;
    assign cnt_pop  = count_q - {1'b0, pop};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;
        case (state_q)
            IDLE: if (bus.redirect_i || cnt_pop < DEPTH_C) state_d = REQ;
            REQ: begin
                if (bus.imem_gnt_i) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = bus.redirect_i ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    if (bus.redirect_i) begin
                        state_d = REQ;
                    end else begin
                        push    = 1'b1;
                        state_d = (cnt_pop + 2'd1 < DEPTH_C) ? REQ : IDLE;
                    end
                end else if (bus.redirect_i) begin
                    state_d = DROP;
                end
            end
            // The stale response is the only thing outstanding; a further
            // redirect here just retargets fetch_pc.
            DROP: if (bus.imem_rvalid_i) state_d = REQ;
            default: state_d = IDLE;
        endcase
        if (bus.redirect_i) fetch_pc_d = {bus.redirect_pc_i[31:2], 2'b00};
    end

    always_comb begin
        count_d   = cnt_pop + {1'b0, push};
        rd_ptr_d  = rd_ptr_q ^ pop;
        wr_ptr_d  = wr_ptr_q ^ push;
        buf_pc_d  = buf_pc_q;
        buf_ins_d = buf_ins_q;
        if (push) begin
            buf_pc_d[wr_ptr_q]  = req_pc_q;
            buf_ins_d[wr_ptr_q] = bus.imem_rdata_i;
        end
        // Flush swallows any same-cycle pop and push.
        if (bus.redirect_i) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            buf_pc_q   <= '0;
            buf_ins_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            buf_pc_q   <= buf_pc_d;
            buf_ins_q  <= buf_ins_d;
        end
    end

    assign head_ins              = head_vld ? buf_ins_q[rd_ptr_q] : NOP;
    assign bus.imem_req_o        = (state_q == REQ);
    assign bus.imem_addr_o       = fetch_pc_q;
    assign bus.inst_valid_o      = head_vld;
    assign bus.Instruction_bus_o = head_ins;
    assign bus.pc_o              = head_vld ? buf_pc_q[rd_ptr_q] : 32'd0;
    assign bus.op_o              = head_ins[6:0];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, streaming, backpressure,
// redirects in WAIT/REQ and asynchronous reset in mid-fetch.
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_fetch_unit_if bus();

    instruction_fetch_unit #(.RESET_PC(32'h0040_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int nfire = 0;
    bit auto_mem = 1'b0;
    int got;
    logic [31:0] got_pc [4];
    logic [31:0] got_ins[4];
    logic [31:0] got_op [4];
    int          got_cyc[4];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Memory word for an address: A5 tag over the low address bits, low bits forced to 2'b11.
    function automatic logic [31:0] word(input logic [31:0] a);
        return {8'hA5, a[23:0]} | 32'h3;
    endfunction

    // Advance one clock; with auto_mem set, answers a grant on the next cycle.
    task automatic step();
        logic        f;
        logic [31:0] a;
        f = bus.imem_req_o && bus.imem_gnt_i;
        a = bus.imem_addr_o;
        @(posedge clk);
        #1;
        if (f) nfire++;
        if (auto_mem) begin
            bus.imem_rvalid_i = f;
            bus.imem_rdata_i  = word(a);
        end
    endtask

    task automatic rst_seq();
        reset             = 1'b0;
        auto_mem          = 1'b0;
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.inst_ready_i  = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic collect(input int n);
        got = 0;
        for (int i = 0; i < 30 && got < n; i++) begin
            if (bus.inst_valid_o && bus.inst_ready_i) begin
                got_pc[got]  = bus.pc_o;
                got_ins[got] = bus.Instruction_bus_o;
                got_op[got]  = {25'd0, bus.op_o};
                got_cyc[got] = i;
                got++;
            end
            step();
        end
    endtask

    initial begin
        logic [31:0] exp_pc [3];
        logic [31:0] exp_ins[3];
        logic [31:0] exp_op [3];
        exp_pc  = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008};
        exp_ins = '{32'hA540_0003, 32'hA540_0007, 32'hA540_000B};
        exp_op  = '{32'h03, 32'h07, 32'h0B};

        reset             = 1'b0;
        bus.imem_gnt_i    = 1'b1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'd0;
        bus.redirect_i    = 1'b0;
        bus.redirect_pc_i = 32'd0;
        bus.inst_ready_i  = 1'b0;

        // reset state
        step(); step();
        chk("rst_req",   {31'd0, bus.imem_req_o},   32'd0);
        chk("rst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        chk("rst_op",    {25'd0, bus.op_o},         32'h13);
        chk("rst_ins",   bus.Instruction_bus_o,     32'h13);
        chk("rst_pc",    bus.pc_o,                  32'd0);
        chk("rst_addr",  bus.imem_addr_o,           32'h0040_0000);
        reset = 1'b1;
        step();
        chk("rel_req",  {31'd0, bus.imem_req_o}, 32'd1);
        chk("rel_addr", bus.imem_addr_o,         32'h0040_0000);

        // streaming, one instruction every two cycles
        auto_mem = 1'b1;
        bus.inst_ready_i = 1'b1;
        collect(3);
        chk("stream_cnt", 32'(got), 32'd3);
        for (int j = 0; j < got && j < 3; j++) begin
            chk($sformatf("stream_pc%0d", j),  got_pc[j],  exp_pc[j]);
            chk($sformatf("stream_ins%0d", j), got_ins[j], exp_ins[j]);
            chk($sformatf("stream_op%0d", j),  got_op[j],  exp_op[j]);
        end
        if (got == 3) chk("stream_rate", 32'(got_cyc[2] - got_cyc[1]), 32'd2);

        // backpressure: buffer fills to two, then one pop frees exactly one request
        rst_seq();
        auto_mem = 1'b1;
        bus.imem_gnt_i = 1'b1;
        repeat (8) step();
        chk("bp_valid", {31'd0, bus.inst_valid_o}, 32'd1);
        chk("bp_req",   {31'd0, bus.imem_req_o},   32'd0);
        nfire = 0;
        repeat (3) step();
        chk("bp_idle_fire", 32'(nfire), 32'd0);
        chk("bp_head_hold", bus.pc_o, 32'h0040_0000);
        bus.inst_ready_i = 1'b1;
        step();
        bus.inst_ready_i = 1'b0;
        chk("bp_req_after_pop", {31'd0, bus.imem_req_o}, 32'd1);
        chk("bp_addr_after_pop", bus.imem_addr_o, 32'h0040_0008);
        chk("bp_head_after_pop", bus.pc_o, 32'h0040_0004);
        nfire = 0;
        repeat (6) step();
        chk("bp_one_fire", 32'(nfire), 32'd1);
        chk("bp_req_full", {31'd0, bus.imem_req_o}, 32'd0);
        bus.inst_ready_i = 1'b1;
        collect(2);
        bus.inst_ready_i = 1'b0;
        chk("bp_drain_cnt", 32'(got), 32'd2);
        for (int j = 0; j < got && j < 2; j++) begin
            chk($sformatf("bp_pc%0d", j),  got_pc[j],  exp_pc[j+1]);
            chk($sformatf("bp_ins%0d", j), got_ins[j], exp_ins[j+1]);
        end

        // redirect in WAIT without rvalid: flush, then drop the stale word
        rst_seq();
        bus.imem_gnt_i = 1'b1;
        step(); step();
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h0040_0000);
        step();
        bus.imem_rvalid_i = 1'b0;
        step();
        chk("rw_pre_valid", {31'd0, bus.inst_valid_o}, 32'd1);
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0040_0103;
        step();
        bus.redirect_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h0040_0004);
        chk("rw_flush_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        chk("rw_flush_ins",   bus.Instruction_bus_o,     32'h13);
        chk("rw_drop_req",    {31'd0, bus.imem_req_o},   32'd0);
        step();
        bus.imem_rvalid_i = 1'b0;
        chk("rw_req",   {31'd0, bus.imem_req_o},   32'd1);
        chk("rw_addr",  bus.imem_addr_o,           32'h0040_0100);
        chk("rw_empty", {31'd0, bus.inst_valid_o}, 32'd0);
        step();
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h0040_0100);
        step();
        bus.imem_rvalid_i = 1'b0;
        bus.imem_gnt_i = 1'b0;
        chk("rw_new_pc",  bus.pc_o,              32'h0040_0100);
        chk("rw_new_ins", bus.Instruction_bus_o, 32'hA540_0103);

        // redirect in REQ without grant: address swaps while the request is held
        rst_seq();
        step();
        chk("rr_req0",  {31'd0, bus.imem_req_o}, 32'd1);
        chk("rr_addr0", bus.imem_addr_o,         32'h0040_0000);
        step();
        bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0040_0200;
        step();
        bus.redirect_i = 1'b0;
        chk("rr_req1",  {31'd0, bus.imem_req_o}, 32'd1);
        chk("rr_addr1", bus.imem_addr_o,         32'h0040_0200);
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h0040_0200);
        chk("rr_wait_req", {31'd0, bus.imem_req_o}, 32'd0);
        step();
        bus.imem_rvalid_i = 1'b0;
        chk("rr_pc",  bus.pc_o,              32'h0040_0200);
        chk("rr_ins", bus.Instruction_bus_o, 32'hA540_0203);
        chk("rr_op",  {25'd0, bus.op_o},     32'h03);
        bus.inst_ready_i = 1'b1;
        step();
        bus.inst_ready_i = 1'b0;
        chk("rr_only_one", {31'd0, bus.inst_valid_o}, 32'd0);

        // asynchronous reset while a fetch is outstanding
        rst_seq();
        bus.imem_gnt_i = 1'b1;
        step(); step();
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h0040_0000);
        step();
        bus.imem_rvalid_i = 1'b0;
        step();
        chk("ar_pre_valid", {31'd0, bus.inst_valid_o}, 32'd1);
        #3 reset = 1'b0;
        #1;
        chk("ar_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        chk("ar_req",   {31'd0, bus.imem_req_o},   32'd0);
        chk("ar_addr",  bus.imem_addr_o,           32'h0040_0000);
        chk("ar_ins",   bus.Instruction_bus_o,     32'h13);
        chk("ar_pc",    bus.pc_o,                  32'd0);
        step();
        reset = 1'b1;
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h0040_0004);
        step();
        bus.imem_rvalid_i = 1'b0;
        chk("ar_late_req",   {31'd0, bus.imem_req_o},   32'd1);
        chk("ar_late_addr",  bus.imem_addr_o,           32'h0040_0000);
        chk("ar_late_valid", {31'd0, bus.inst_valid_o}, 32'd0);
        bus.imem_gnt_i = 1'b1;
        step();
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b1; bus.imem_rdata_i = word(32'h0040_0000);
        step();
        bus.imem_rvalid_i = 1'b0;
        chk("ar_restart_pc",  bus.pc_o,              32'h0040_0000);
        chk("ar_restart_ins", bus.Instruction_bus_o, 32'hA540_0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
